// File: rtl/rf_pkg.sv
// Shared constants, state encoding and beat format for the register-file
// read-side stream sequencer.
package rf_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;
  localparam int FIFO_D = 4;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Requested word counts above the array size are limited to one full pass.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
  endfunction

endpackage

// File: rtl/rf_stream_reader_if.sv
// Valid/ready word stream carrying register-file contents with an end marker.
interface rf_stream_reader_if;
  import rf_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/rf_rd_fifo.sv
// Four-entry synchronous buffer of {last, data} beats between the macro read
// port and the output stream; head outputs are zero whenever it is empty.
module rf_rd_fifo
  import rf_pkg::*;
(
  input  logic       clka,
  input  logic       rstn,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic       not_empty,
  output logic [2:0] count
);

  beat_t      mem_q [4];
  beat_t      mem_d [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop && (cnt_q != 3'd0);
    do_push = push && ((cnt_q != 3'd4) || do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_beat;
      wr_d        = wr_q + 2'd1;
    end
    if (do_pop) begin
      rd_d = rd_q + 2'd1;
    end
    cnt_d = cnt_q + 3'(do_push) - 3'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is gated by not_empty.
  always_ff @(posedge clka) begin
    mem_q <= mem_d;
  end

  assign not_empty = (cnt_q != 3'd0);
  assign head      = not_empty ? mem_q[rd_q] : '0;
  assign count     = cnt_q;

endmodule

// File: rtl/rf_stream_reader.sv
// Issues sequential reads on the register-file B port and streams the words
// out with backpressure, holding at most FIFO_D words buffered or in flight.
module rf_stream_reader #(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int DEPTH  = rf_pkg::DEPTH,
  parameter int FIFO_D = rf_pkg::FIFO_D
) (
  input  logic                     clka,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [rf_pkg::CNT_W-1:0] count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        rf_addrb,
  input  logic [DATA_W-1:0]        rf_doutb,
  rf_stream_reader_if.master       m
);
  import rf_pkg::*;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  remain_q, remain_d, clamped;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              issue, credit_ok, fifo_pop, fifo_valid;
  logic [2:0]        fifo_count;
  beat_t             push_beat, head;

  assign push_beat = '{last: inflight_last_q, data: rf_doutb};

  rf_rd_fifo u_fifo (
    .clka      (clka),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (fifo_pop),
    .head      (head),
    .not_empty (fifo_valid),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    issue     = 1'b0;
    clamped   = clamp_count(count);
    fifo_pop  = fifo_valid & m.ready;
    // Credit counts the read still in the macro pipe; m.ready is not involved.
    credit_ok = (4'(fifo_count) + 4'(inflight_q)) <= 4'(FIFO_D - 1);
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d    = base_addr;
          remain_d = clamped;
          state_d  = (clamped == '0) ? DONE : READ;
        end
      end
      READ: begin
        if ((remain_q != '0) && credit_ok) begin
          issue    = 1'b1;
          ptr_d    = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && head.last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && (remain_q == CNT_W'(1));
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge clka) begin
    if (!rstn) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rf_addrb = ptr_q;
  assign m.valid  = fifo_valid;
  assign m.data   = head.data;
  assign m.last   = head.last;

endmodule
